// File: rtl/decode_ctrl_pipe.sv
`timescale 1ns/1ps
// decode_ctrl_pipe
// Decodes a multi-slot instruction bundle (ALU slots, one MDU slot, one BRU
// slot) into per-slot control signals. The decoded bundle is held in a
// two-entry elastic buffer: an output register plus a skid register, so the
// upstream ready can be a register while the pipe still runs at full rate.
module decode_ctrl_pipe #(
    parameter int ALU_NUM  = 2,
    parameter int SLOT_NUM = ALU_NUM + 2,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7*SLOT_NUM-1:0] opcode_in,
    input  logic [3*SLOT_NUM-1:0] func3_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*ALU_NUM-1:0]  aluop,
    output logic [ALU_NUM-1:0]    alusrc,
    output logic [ALU_NUM-1:0]    alusrc_pc,
    output logic [ALU_NUM-1:0]    memread,
    output logic [ALU_NUM-1:0]    memwrite,
    output logic [3*ALU_NUM-1:0]  rw_type,
    output logic [7:0]            br_op,
    output logic [SLOT_NUM-1:0]   regwrite,
    output logic [SLOT_NUM-1:0]   illegal,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int PW = 10*ALU_NUM + 8 + 2*SLOT_NUM;

    localparam logic [6:0] OP_NONE  = 7'b0000000;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RW    = 7'b0111011;
    localparam logic [6:0] OP_IW    = 7'b0011011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Buffer occupancy: nothing, output register only, output + skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_t;

    // ALU slot decode, packed as
    // {aluop[2:0], alusrc, alusrc_pc, memread, memwrite, rw_type[2:0], regwrite, illegal}
    function automatic logic [11:0] dec_alu(input logic [6:0] op, input logic [2:0] f3);
        logic [11:0] d;
        d = 12'd0;
        case (op)
            OP_R:     d = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
            OP_I:     d = {3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
            OP_RW:    d = {3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
            OP_IW:    d = {3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
            OP_LOAD:  d = {3'b100, 1'b1, 1'b0, 1'b1, 1'b0, f3,     1'b1, 1'b0};
            OP_STORE: d = {3'b100, 1'b1, 1'b0, 1'b0, 1'b1, f3,     1'b0, 1'b0};
            OP_AUIPC: d = {3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
            OP_LUI:   d = {3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
            OP_NONE:  d = 12'd0;
            default:  d = 12'd1;
        endcase
        return d;
    endfunction

    // MDU slot decode, packed as {regwrite, illegal}
    function automatic logic [1:0] dec_mdu(input logic [6:0] op);
        logic [1:0] d;
        case (op)
            OP_R, OP_RW: d = 2'b10;
            OP_NONE:     d = 2'b00;
            default:     d = 2'b01;
        endcase
        return d;
    endfunction

    // BRU slot decode, packed as {br_op[7:0], regwrite, illegal}
    function automatic logic [9:0] dec_bru(input logic [6:0] op, input logic [2:0] f3);
        logic [9:0] d;
        case (op)
            OP_JAL:  d = {8'b0000_0001, 1'b1, 1'b0};
            OP_JALR: d = {8'b0000_0010, 1'b1, 1'b0};
            OP_B: begin
                case (f3)
                    3'b000:  d = {8'b0000_0100, 1'b0, 1'b0};
                    3'b001:  d = {8'b0000_1000, 1'b0, 1'b0};
                    3'b100:  d = {8'b0001_0000, 1'b0, 1'b0};
                    3'b101:  d = {8'b0010_0000, 1'b0, 1'b0};
                    3'b110:  d = {8'b0100_0000, 1'b0, 1'b0};
                    3'b111:  d = {8'b1000_0000, 1'b0, 1'b0};
                    default: d = {8'b0000_0000, 1'b0, 1'b1};
                endcase
            end
            OP_NONE: d = 10'd0;
            default: d = {8'b0000_0000, 1'b0, 1'b1};
        endcase
        return d;
    endfunction

    logic [3*ALU_NUM-1:0] w_aluop;
    logic [ALU_NUM-1:0]   w_alusrc;
    logic [ALU_NUM-1:0]   w_alusrc_pc;
    logic [ALU_NUM-1:0]   w_memread;
    logic [ALU_NUM-1:0]   w_memwrite;
    logic [3*ALU_NUM-1:0] w_rw_type;
    logic [7:0]           w_br_op;
    logic [SLOT_NUM-1:0]  w_regwrite;
    logic [SLOT_NUM-1:0]  w_illegal;
    logic [PW-1:0]        w_dec;
    logic                 w_unused_mdu_f3;

    genvar g;
    for (g = 0; g < ALU_NUM; g++) begin : g_alu
        logic [11:0] w_d;
        assign w_d                 = dec_alu(opcode_in[7*g +: 7], func3_in[3*g +: 3]);
        assign w_aluop[3*g +: 3]   = w_d[11:9];
        assign w_alusrc[g]         = w_d[8];
        assign w_alusrc_pc[g]      = w_d[7];
        assign w_memread[g]        = w_d[6];
        assign w_memwrite[g]       = w_d[5];
        assign w_rw_type[3*g +: 3] = w_d[4:2];
        assign w_regwrite[g]       = w_d[1];
        assign w_illegal[g]        = w_d[0];
    end

    assign {w_regwrite[ALU_NUM], w_illegal[ALU_NUM]} = dec_mdu(opcode_in[7*ALU_NUM +: 7]);
    assign {w_br_op, w_regwrite[ALU_NUM+1], w_illegal[ALU_NUM+1]} =
        dec_bru(opcode_in[7*(ALU_NUM+1) +: 7], func3_in[3*(ALU_NUM+1) +: 3]);
    // The MDU slot has no func3-dependent control.
    assign w_unused_mdu_f3 = ^func3_in[3*ALU_NUM +: 3];

    assign w_dec = {w_aluop, w_alusrc, w_alusrc_pc, w_memread, w_memwrite,
                    w_rw_type, w_br_op, w_regwrite, w_illegal};

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_out_valid;
    logic          r_in_ready;
    logic [PW-1:0] r_out_data;
    logic [PW-1:0] r_skid_data;
    logic [CNT_W-1:0] r_stall_cnt;
    logic          w_accept;
    logic          w_out_load;
    logic          w_out_from_skid;
    logic          w_skid_load;

    // A bundle arriving in a flush cycle is dropped rather than accepted.
    assign w_accept = in_valid & r_in_ready & ~flush;

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next occupancy and buffer load selects; flush overrides every other event.
    always_comb begin
        w_state_nxt     = r_state;
        w_out_load      = 1'b0;
        w_out_from_skid = 1'b0;
        w_skid_load     = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_out_load  = 1'b1;
                        w_state_nxt = ST_ONE;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (out_ready) begin
                        if (w_accept) begin
                            w_out_load  = 1'b1;
                            w_state_nxt = ST_ONE;
                        end else begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end else begin
                        if (w_accept) begin
                            w_skid_load = 1'b1;
                            w_state_nxt = ST_TWO;
                        end else begin
                            w_state_nxt = ST_ONE;
                        end
                    end
                end
                ST_TWO: begin
                    if (out_ready) begin
                        w_out_from_skid = 1'b1;
                        w_state_nxt     = ST_ONE;
                    end else begin
                        w_state_nxt = ST_TWO;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake flags registered from the next occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_TWO);
        end
    end

    // Output register: refilled from skid first, else from the decoder; zeroed when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= {PW{1'b0}};
        end else if (w_out_from_skid) begin
            r_out_data <= r_skid_data;
        end else if (w_out_load) begin
            r_out_data <= w_dec;
        end else if (w_state_nxt == ST_EMPTY) begin
            r_out_data <= {PW{1'b0}};
        end else begin
            r_out_data <= r_out_data;
        end
    end

    // Skid register captures a bundle accepted while the output is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_data <= {PW{1'b0}};
        end else if (w_skid_load) begin
            r_skid_data <= w_dec;
        end else begin
            r_skid_data <= r_skid_data;
        end
    end

    // Saturating count of back-pressured output cycles; flush does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign {aluop, alusrc, alusrc_pc, memread, memwrite,
            rw_type, br_op, regwrite, illegal} = r_out_data;
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
`timescale 1ns/1ps
// Bench for decode_ctrl_pipe: directed scenarios plus random traffic checked
// against a queue-based reference model of the two-entry buffer.
module tb_decode_ctrl_pipe;

    localparam int A  = 2;
    localparam int S  = A + 2;
    localparam int CW = 16;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RW    = 7'b0111011;
    localparam logic [6:0] OP_IW    = 7'b0011011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_NONE  = 7'b0000000;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic in_valid;
    logic in_ready;
    logic [7*S-1:0] opcode_in;
    logic [3*S-1:0] func3_in;
    logic out_valid;
    logic out_ready;
    logic [3*A-1:0] aluop;
    logic [A-1:0]   alusrc;
    logic [A-1:0]   alusrc_pc;
    logic [A-1:0]   memread;
    logic [A-1:0]   memwrite;
    logic [3*A-1:0] rw_type;
    logic [7:0]     br_op;
    logic [S-1:0]   regwrite;
    logic [S-1:0]   illegal;
    logic [CW-1:0]  stall_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3*A-1:0] aluop;
        logic [A-1:0]   alusrc;
        logic [A-1:0]   alusrc_pc;
        logic [A-1:0]   memread;
        logic [A-1:0]   memwrite;
        logic [3*A-1:0] rw_type;
        logic [7:0]     br_op;
        logic [S-1:0]   regwrite;
        logic [S-1:0]   illegal;
    } exp_t;

    exp_t          q[$];
    logic [CW-1:0] m_cnt;

    decode_ctrl_pipe #(.ALU_NUM(A), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode_in(opcode_in), .func3_in(func3_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluop(aluop), .alusrc(alusrc), .alusrc_pc(alusrc_pc),
        .memread(memread), .memwrite(memwrite), .rw_type(rw_type),
        .br_op(br_op), .regwrite(regwrite), .illegal(illegal),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Spec-level decode of one bundle, written from the boolean rules.
    function automatic exp_t ref_decode(input logic [7*S-1:0] ops, input logic [3*S-1:0] f3s);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f;
        logic is_r, is_i, is_ld, is_st, is_rw, is_iw, is_lui, is_aup, is_jal, is_jalr;
        int pos [8];
        pos = '{2, 3, -1, -1, 4, 5, 6, 7};
        e.aluop = '0; e.alusrc = '0; e.alusrc_pc = '0; e.memread = '0;
        e.memwrite = '0; e.rw_type = '0; e.br_op = '0; e.regwrite = '0; e.illegal = '0;
        for (int k = 0; k < A; k++) begin
            op = ops[7*k +: 7];
            f  = f3s[3*k +: 3];
            is_r = (op == OP_R);   is_i = (op == OP_I);   is_ld = (op == OP_LOAD);
            is_st = (op == OP_STORE); is_rw = (op == OP_RW); is_iw = (op == OP_IW);
            is_lui = (op == OP_LUI); is_aup = (op == OP_AUIPC);
            if (is_r)                         e.aluop[3*k +: 3] = 3'd0;
            else if (is_i)                    e.aluop[3*k +: 3] = 3'd1;
            else if (is_rw)                   e.aluop[3*k +: 3] = 3'd2;
            else if (is_iw)                   e.aluop[3*k +: 3] = 3'd3;
            else if (is_ld || is_st || is_aup) e.aluop[3*k +: 3] = 3'd4;
            else if (is_lui)                  e.aluop[3*k +: 3] = 3'd5;
            else                              e.aluop[3*k +: 3] = 3'd0;
            e.alusrc[k]    = is_ld | is_st | is_i | is_iw | is_aup;
            e.alusrc_pc[k] = is_aup;
            e.memread[k]   = is_ld;
            e.memwrite[k]  = is_st;
            e.rw_type[3*k +: 3] = (is_ld || is_st) ? f : 3'b000;
            e.regwrite[k]  = is_ld | is_i | is_r | is_lui | is_aup | is_rw | is_iw;
            e.illegal[k]   = (op != OP_NONE) &&
                             !(is_r | is_i | is_ld | is_st | is_rw | is_iw | is_lui | is_aup);
        end
        op = ops[7*A +: 7];
        e.regwrite[A] = (op == OP_R) || (op == OP_RW);
        e.illegal[A]  = (op != OP_NONE) && !e.regwrite[A];
        op = ops[7*(A+1) +: 7];
        f  = f3s[3*(A+1) +: 3];
        is_jal  = (op == OP_JAL);
        is_jalr = (op == OP_JALR);
        e.br_op[0] = is_jal;
        e.br_op[1] = is_jalr;
        e.regwrite[A+1] = is_jal | is_jalr;
        if (op == OP_B) begin
            if (pos[f] >= 0) e.br_op[pos[f]] = 1'b1;
            else e.illegal[A+1] = 1'b1;
        end else begin
            e.illegal[A+1] = (op != OP_NONE) && !(is_jal || is_jalr);
        end
        return e;
    endfunction

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 13))
            0:  return OP_R;
            1:  return OP_I;
            2:  return OP_LOAD;
            3:  return OP_STORE;
            4:  return OP_RW;
            5:  return OP_IW;
            6:  return OP_LUI;
            7:  return OP_AUIPC;
            8:  return OP_B;
            9:  return OP_JAL;
            10: return OP_JALR;
            11: return OP_NONE;
            default: return 7'($urandom_range(0, 127));
        endcase
    endfunction

    task automatic set_in(input logic v, input logic [6:0] o0, input logic [6:0] o1,
                          input logic [6:0] o2, input logic [6:0] o3,
                          input logic [2:0] f0, input logic [2:0] f1,
                          input logic [2:0] f2, input logic [2:0] f3);
        in_valid  = v;
        opcode_in = {o3, o2, o1, o0};
        func3_in  = {f3, f2, f1, f0};
    endtask

    // Advance the model across one rising edge using the inputs seen at that edge.
    task automatic model_edge();
        bit mv;
        bit mr;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt = '0;
        end else begin
            mv = (q.size() > 0);
            mr = (q.size() < 2);
            if (mv && !out_ready && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
            if (flush) begin
                q.delete();
            end else begin
                if (mv && out_ready) void'(q.pop_front());
                if (in_valid && mr) q.push_back(ref_decode(opcode_in, func3_in));
            end
        end
    endtask

    task automatic step();
        model_edge();
        #1;
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        if (q.size() > 0) begin
            chk("aluop", 64'(aluop), 64'(q[0].aluop));
            chk("alusrc", 64'(alusrc), 64'(q[0].alusrc));
            chk("alusrc_pc", 64'(alusrc_pc), 64'(q[0].alusrc_pc));
            chk("memread", 64'(memread), 64'(q[0].memread));
            chk("memwrite", 64'(memwrite), 64'(q[0].memwrite));
            chk("rw_type", 64'(rw_type), 64'(q[0].rw_type));
            chk("br_op", 64'(br_op), 64'(q[0].br_op));
            chk("regwrite", 64'(regwrite), 64'(q[0].regwrite));
            chk("illegal", 64'(illegal), 64'(q[0].illegal));
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, OP_NONE, OP_NONE, OP_NONE, OP_NONE, 3'd0, 3'd0, 3'd0, 3'd0);
        m_cnt = '0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_ctrl", 64'({aluop, alusrc, memread, memwrite, br_op, regwrite, illegal}), 64'd0);
        step();
        step();
        @(negedge clk) rst = 1'b0;

        // Mixed ALU bundle with immediate consumption.
        out_ready = 1'b1;
        set_in(1'b1, OP_R, OP_LOAD, OP_NONE, OP_NONE, 3'b000, 3'b011, 3'b000, 3'b000);
        step();
        chk("d_aluop", 64'(aluop), 64'(6'b100_000));
        chk("d_memread", 64'(memread), 64'(2'b10));
        chk("d_rw_type_hi", 64'(rw_type[5:3]), 64'(3'b011));
        chk("d_regwrite_lo", 64'(regwrite[1:0]), 64'(2'b11));

        // Branch decode: bge, then a reserved func3.
        set_in(1'b1, OP_NONE, OP_NONE, OP_NONE, OP_B, 3'b000, 3'b000, 3'b000, 3'b101);
        step();
        chk("bge_br_op", 64'(br_op), 64'(8'b0010_0000));
        chk("bge_regwrite3", 64'(regwrite[3]), 64'd0);
        set_in(1'b1, OP_NONE, OP_NONE, OP_NONE, OP_B, 3'b000, 3'b000, 3'b000, 3'b010);
        step();
        chk("b010_illegal3", 64'(illegal[3]), 64'd1);
        chk("b010_br_op", 64'(br_op), 64'd0);

        // MDU slot legality.
        set_in(1'b1, OP_NONE, OP_NONE, OP_RW, OP_NONE, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        chk("mdu_rw_regwrite2", 64'(regwrite[2]), 64'd1);
        set_in(1'b1, OP_NONE, OP_NONE, OP_I, OP_NONE, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        chk("mdu_i_illegal2", 64'(illegal[2]), 64'd1);
        chk("mdu_i_regwrite2", 64'(regwrite[2]), 64'd0);
        in_valid = 1'b0;
        step();

        // Back-pressure: A held, B in skid, C refused until drained.
        out_ready = 1'b0;
        set_in(1'b1, OP_I, OP_STORE, OP_R, OP_JAL, 3'd0, 3'b010, 3'd0, 3'd0);
        step();
        set_in(1'b1, OP_AUIPC, OP_LUI, OP_RW, OP_JALR, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        set_in(1'b1, OP_IW, OP_LOAD, OP_NONE, OP_B, 3'd0, 3'b001, 3'd0, 3'b000);
        step();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("bp_hold_A_aluop", 64'(aluop), 64'(6'b100_001));
        chk("bp_hold_A_br_op", 64'(br_op), 64'(8'b0000_0001));
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd3);
        out_ready = 1'b1;
        step();
        chk("bp_B_aluop", 64'(aluop), 64'(6'b101_100));
        chk("bp_B_br_op", 64'(br_op), 64'(8'b0000_0010));
        step();
        chk("bp_C_aluop", 64'(aluop), 64'(6'b100_011));
        chk("bp_C_br_op", 64'(br_op), 64'(8'b0000_0100));
        in_valid = 1'b0;
        step();

        // Random traffic with occasional flush.
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            opcode_in = {rand_op(), rand_op(), rand_op(), rand_op()};
            func3_in  = 12'($urandom);
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        // Flush with both entries full and a bundle offered.
        out_ready = 1'b0;
        set_in(1'b1, OP_R, OP_I, OP_R, OP_JAL, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        set_in(1'b1, OP_LUI, OP_IW, OP_RW, OP_JALR, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        set_in(1'b1, OP_LOAD, OP_LOAD, OP_NONE, OP_B, 3'd2, 3'd4, 3'd0, 3'd7);
        flush = 1'b1;
        step();
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_no_emit", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset in the middle of a transfer.
        out_ready = 1'b0;
        set_in(1'b1, OP_R, OP_R, OP_R, OP_JAL, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        set_in(1'b1, OP_I, OP_I, OP_RW, OP_JALR, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        q.delete();
        m_cnt = '0;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("arst_ctrl", 64'({aluop, regwrite, br_op}), 64'd0);
        step();
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Stall counter saturation, then reset clears it.
        out_ready = 1'b0;
        set_in(1'b1, OP_R, OP_I, OP_R, OP_JAL, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 65540; i++) model_edge();
        #1;
        chk("sat_stall_cnt", 64'(stall_cnt), 64'h0000_0000_0000_FFFF);
        step();
        chk("sat_hold", 64'(stall_cnt), 64'h0000_0000_0000_FFFF);
        @(negedge clk) rst = 1'b1;
        #1;
        q.delete();
        m_cnt = '0;
        chk("sat_rst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk) rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
